// File: rtl/dm_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// After reset it can zero-fill the whole memory before accepting requests.
module dm_arbiter #(
  parameter int unsigned CLEAR_ON_RESET = 1,
  parameter int unsigned ADDR_W         = 5,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  // Handshake: a requester raises req with we/addr/wdata and holds all of them
  // stable until it sees gnt high; gnt is a one-cycle pulse marking the cycle the
  // access is issued. A req still high in the cycle after gnt is a new request.
  // Reads return rdata with a one-cycle rvalid pulse in the cycle after gnt.
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] memReadData,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_ACCESS = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e              state_q;
  logic [ADDR_W-1:0]   clear_cnt_q;
  logic                last_gnt_q;
  logic                gnt0_q;
  logic                gnt1_q;
  logic                rvalid0_q;
  logic                rvalid1_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;
  logic                busy_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                mem_write_q;
  logic                mem_read_q;

  logic                any_req_d;
  logic                pick1_d;
  logic                win_we_d;
  logic [ADDR_W-1:0]   win_addr_d;
  logic [DATA_W-1:0]   win_wdata_d;

  // last_gnt_q = 1 means requester 1 was granted last, so requester 0 wins a tie.
  always_comb begin
    any_req_d   = req0 | req1;
    pick1_d     = req1 & (~req0 | ~last_gnt_q);
    win_we_d    = pick1_d ? we1    : we0;
    win_addr_d  = pick1_d ? addr1  : addr0;
    win_wdata_d = pick1_d ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
      clear_cnt_q <= '0;
      last_gnt_q  <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          // busy_q low here only in the first fill cycle after reset.
          if (!busy_q) begin
            busy_q      <= 1'b1;
            mem_write_q <= 1'b1;
            mem_read_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_addr_q  <= '0;
            clear_cnt_q <= '0;
          end else if (clear_cnt_q == LAST_ADDR) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            clear_cnt_q <= '0;
          end else begin
            clear_cnt_q <= clear_cnt_q + 1'b1;
            mem_addr_q  <= clear_cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (any_req_d) begin
            state_q     <= S_ACCESS;
            gnt0_q      <= ~pick1_d;
            gnt1_q      <= pick1_d;
            last_gnt_q  <= pick1_d;
            mem_write_q <= win_we_d;
            mem_read_q  <= ~win_we_d;
            mem_addr_q  <= win_addr_d;
            mem_wdata_q <= win_wdata_d;
          end
        end
        S_ACCESS: begin
          state_q     <= S_IDLE;
          mem_write_q <= 1'b0;
          mem_read_q  <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          // The registered gnt still identifies the winner during ACCESS.
          if (mem_read_q) begin
            if (gnt1_q) begin
              rdata1_q  <= memReadData;
              rvalid1_q <= 1'b1;
            end else begin
              rdata0_q  <= memReadData;
              rvalid0_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign busy      = busy_q;
  assign memAddr   = mem_addr_q;
  assign memWData  = mem_wdata_q;
  assign memWrite  = mem_write_q;
  assign memRead   = mem_read_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed vector table, hand-written reset/clear
// sequences and randomized traffic checked by a transaction-level model.
module tb_dm_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 32;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, memWrite, memRead;
  logic [DW-1:0] rdata0, rdata1, memWData, memReadData;
  logic [AW-1:0] memAddr;
  logic [1:0]    dbg_state;

  dm_arbiter #(.CLEAR_ON_RESET(1), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .memAddr(memAddr), .memWData(memWData), .memWrite(memWrite), .memRead(memRead),
    .memReadData(memReadData), .dbg_state(dbg_state)
  );

  // Memory starts with garbage so the zero-fill is observable.
  logic [DW-1:0] tb_mem [DEPTH];
  bit mem_seeded = 1'b0;
  always @(posedge clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= $urandom;
      mem_seeded <= 1'b1;
    end else if (memWrite) begin
      tb_mem[memAddr] <= memWData;
    end
  end
  assign memReadData = tb_mem[memAddr];

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Cycle count since reset release: cycles 1..32 are the fill, a request
  // sampled at an edge is served only if the cycle before it was idle.
  bit            mon_en = 1'b0;
  int            m_cnt, exp_gnt_prev, exp_rv, win;
  bit            m_last, idle_edge, exp_busy, c_we;
  logic [AW-1:0] c_a;
  logic [DW-1:0] c_d;
  logic [DW:0]   e;
  logic [DW-1:0] m_rdata [2];
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW:0]   exp_q [$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (reset) begin
        chk("rst gnt", {gnt1, gnt0}, 0);
        chk("rst rvalid", {rvalid1, rvalid0}, 0);
        chk("rst busy", busy, 0);
        chk("rst strobes", {memRead, memWrite}, 0);
        chk("rst memaddr", memAddr, 0);
        chk("rst memwdata", memWData, 0);
        chk("rst rdata0", rdata0, 0);
        chk("rst rdata1", rdata1, 0);
        m_cnt = 0; exp_gnt_prev = -1; exp_rv = -1; m_last = 1'b1;
        m_rdata[0] = '0; m_rdata[1] = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_q.delete();
      end else begin
        idle_edge = (m_cnt >= 33) && (exp_gnt_prev < 0);
        if (m_cnt < 1000) m_cnt++;
        exp_busy = (m_cnt <= 32);
        win = -1;
        if (idle_edge && (req0 || req1)) begin
          if (req0 && req1) win = m_last ? 0 : 1;
          else              win = req1 ? 1 : 0;
          m_last = (win == 1);
        end
        chk("busy", busy, exp_busy);
        chk("gnt0", gnt0, win == 0);
        chk("gnt1", gnt1, win == 1);
        // read return for the previous cycle's grant
        chk("rvalid0", rvalid0, exp_rv == 0);
        chk("rvalid1", rvalid1, exp_rv == 1);
        if (exp_rv >= 0) begin
          if (exp_q.size() == 0) chk("sb underflow", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("sb who", e[DW], exp_rv);
            m_rdata[e[DW]] = e[DW-1:0];
          end
        end
        chk("rdata0", rdata0, m_rdata[0]);
        chk("rdata1", rdata1, m_rdata[1]);
        if (exp_busy) begin
          chk("clr strobes", {memRead, memWrite}, 2'b01);
          chk("clr addr", memAddr, m_cnt - 1);
          chk("clr wdata", memWData, 0);
        end else if (win >= 0) begin
          c_we = (win == 1) ? we1 : we0;
          c_a  = (win == 1) ? addr1 : addr0;
          c_d  = (win == 1) ? wdata1 : wdata0;
          chk("cmd strobes", {memRead, memWrite}, c_we ? 2'b01 : 2'b10);
          chk("cmd addr", memAddr, c_a);
          if (c_we) begin
            chk("cmd wdata", memWData, c_d);
            ref_mem[c_a] = c_d;
          end else begin
            exp_q.push_back({win[0], ref_mem[c_a]});
          end
        end else begin
          chk("idle strobes", {memRead, memWrite}, 0);
        end
        exp_rv       = (win >= 0 && !c_we) ? win : -1;
        exp_gnt_prev = win;
      end
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [DW-1:0] d1;
    logic g0, g1, v0, v1; logic [DW-1:0] q0, q1;
  } vec_t;
  vec_t tbl [$];
  logic [DW-1:0] cur_rd0, cur_rd1;

  task automatic add_row(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic g0, input logic g1, input logic v0, input logic v1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.q0 = cur_rd0; v.q1 = cur_rd1;
    tbl.push_back(v);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk); #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_clear();
    int bc;
    bc = 0;
    repeat (32) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("clear busy cycles", bc, 32);
    @(negedge clk);
    chk("busy after clear", busy, 0);
  endtask

  task automatic new_cmd(output logic r, output logic w, output logic [AW-1:0] a,
                         output logic [DW-1:0] d);
    r = 1'b1;
    w = ($urandom_range(0, 1) == 1);
    a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1)) : AW'($urandom_range(0, 7));
    d = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n, early;
    reset = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    mon_en = 1'b1;

    // Fill after reset: 32 busy write cycles over addresses 0..31.
    do_reset();
    wait_clear();

    cur_rd0 = '0; cur_rd1 = '0;
    add_row(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0,            1, 0, 0, 0);
    add_row(1, 0, 5, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    add_row(1, 0, 5, 0,            0, 0, 0, 0,            1, 0, 0, 0);
    cur_rd0 = 32'hDEADBEEF;
    add_row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 1, 0);
    add_row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    add_row(1, 0, 31, 0,           1, 0, 5, 0,            0, 1, 0, 0);
    cur_rd1 = 32'hDEADBEEF;
    add_row(1, 0, 31, 0,           1, 1, 7, 32'h12345678, 0, 0, 0, 1);
    add_row(1, 0, 31, 0,           1, 1, 7, 32'h12345678, 1, 0, 0, 0);
    cur_rd0 = 32'h0;
    add_row(0, 0, 0, 0,            1, 1, 7, 32'h12345678, 0, 0, 1, 0);
    add_row(0, 0, 0, 0,            1, 1, 7, 32'h12345678, 0, 1, 0, 0);
    add_row(0, 0, 0, 0,            0, 0, 0, 0,            0, 0, 0, 0);
    // Both held: grants alternate 0,1,0,1,... on every other cycle.
    for (int k = 0; k < 16; k++) begin
      int who;
      who = (k / 2) % 2;
      if (k % 2 == 0) begin
        add_row(1, 0, 5, 0, 1, 0, 7, 0, who == 0, who == 1, 0, 0);
      end else begin
        if (who == 0) cur_rd0 = 32'hDEADBEEF;
        else          cur_rd1 = 32'h12345678;
        add_row(1, 0, 5, 0, 1, 0, 7, 0, 0, 0, who == 0, who == 1);
      end
    end

    for (int i = 0; i < tbl.size(); i++) begin
      #1;
      req0 = tbl[i].r0; we0 = tbl[i].w0; addr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      req1 = tbl[i].r1; we1 = tbl[i].w1; addr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      @(negedge clk);
      chk($sformatf("vec%0d gnt0", i), gnt0, tbl[i].g0);
      chk($sformatf("vec%0d gnt1", i), gnt1, tbl[i].g1);
      chk($sformatf("vec%0d rvalid0", i), rvalid0, tbl[i].v0);
      chk($sformatf("vec%0d rvalid1", i), rvalid1, tbl[i].v1);
      chk($sformatf("vec%0d rdata0", i), rdata0, tbl[i].q0);
      chk($sformatf("vec%0d rdata1", i), rdata1, tbl[i].q1);
      chk($sformatf("vec%0d gnt excl", i), gnt0 & gnt1, 0);
    end

    // Reset in the ACCESS cycle of a read: no rvalid, fill restarts at 0.
    #1 req0 = 1; we0 = 0; addr0 = 5; req1 = 0;
    @(negedge clk);
    chk("acc-rst gnt0", gnt0, 1);
    #1 req0 = 0; reset = 1;
    @(negedge clk);
    chk("acc-rst rvalid0", rvalid0, 0);
    chk("acc-rst gnt0 clr", gnt0, 0);
    chk("acc-rst rdata0", rdata0, 0);
    @(negedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("acc-rst busy", busy, 1);
    chk("acc-rst addr0", memAddr, 0);
    chk("acc-rst write", memWrite, 1);
    @(negedge clk);
    chk("acc-rst addr1", memAddr, 1);

    // Reset in the middle of the fill restarts it from address 0.
    repeat (6) @(negedge clk);
    #1 reset = 1;
    @(negedge clk);
    chk("clr-rst busy", busy, 0);
    #1 reset = 0;
    @(negedge clk);
    chk("clr-rst addr", memAddr, 0);
    chk("clr-rst busy1", busy, 1);

    // req1 read raised in fill cycle 3 waits for the end of the fill.
    repeat (2) @(negedge clk);
    #1 req1 = 1; we1 = 0; addr1 = 31;
    n = 0; early = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy && gnt1) early++;
    end while (busy && n < 100);
    chk("pend busy falls", busy, 0);
    chk("pend no gnt in fill", early, 0);
    chk("pend no gnt first idle", gnt1, 0);
    @(negedge clk);
    chk("pend gnt1", gnt1, 1);
    #1 req1 = 0;
    @(negedge clk);
    chk("pend rvalid1", rvalid1, 1);
    chk("pend rdata1 zero", rdata1, 0);

    // Randomized traffic, checked by the model.
    repeat (1500) begin
      @(negedge clk);
      #1;
      if (req0 && gnt0) begin
        if ($urandom_range(0, 1) == 1) new_cmd(req0, we0, addr0, wdata0);
        else req0 = 0;
      end else if (!req0 && $urandom_range(0, 2) == 0) begin
        new_cmd(req0, we0, addr0, wdata0);
      end
      if (req1 && gnt1) begin
        if ($urandom_range(0, 1) == 1) new_cmd(req1, we1, addr1, wdata1);
        else req1 = 0;
      end else if (!req1 && $urandom_range(0, 2) == 0) begin
        new_cmd(req1, we1, addr1, wdata1);
      end
    end
    // Let any in-flight grant retire before dropping the requests.
    @(negedge clk);
    #1;
    if (gnt0) req0 = 0;
    if (gnt1) req1 = 0;
    n = 0;
    while ((req0 || req1) && n < 20) begin
      @(negedge clk);
      #1;
      if (gnt0) req0 = 0;
      if (gnt1) req1 = 0;
      n++;
    end
    chk("random drain", req0 | req1, 0);
    repeat (4) @(negedge clk);
    chk("scoreboard empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
